// File: rtl/e203_itcm_sram_ctrl.sv
// ITCM SRAM initiator: ICB command to SRAM pins, one-cycle read capture, 2-deep response FIFO.
// Optional light-sleep entry/wake controlled by macro E203_ITCM_CTRL_LS_EN.
module e203_itcm_sram_ctrl #(
  parameter int DP          = 8192,
  parameter int AW          = 13,
  parameter int DW          = 64,
  parameter int MW          = 8,
  parameter int IDLE_LS_CYC = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          icb_cmd_valid,
  output logic          icb_cmd_ready,
  input  logic          icb_cmd_read,
  input  logic [AW-1:0] icb_cmd_addr,
  input  logic [DW-1:0] icb_cmd_wdata,
  input  logic [MW-1:0] icb_cmd_wmask,
  output logic          icb_rsp_valid,
  input  logic          icb_rsp_ready,
  output logic [DW-1:0] icb_rsp_rdata,
  output logic          icb_rsp_err,
  output logic          ram_cs,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [MW-1:0] ram_wem,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,
  output logic          ram_sd,
  output logic          ram_ds,
  output logic          ram_ls
);

  if (DP < 1 || DP > (1 << AW)) begin : g_bad_dp
    $error("DP must lie in 1..2**AW");
  end
  if (MW * 8 != DW) begin : g_bad_mw
    $error("MW must equal DW/8");
  end
  if (IDLE_LS_CYC < 1 || IDLE_LS_CYC > 255) begin : g_bad_idle
    $error("IDLE_LS_CYC must lie in 1..255");
  end

  logic          s1_vld_q, s1_vld_d;
  logic          s1_read_q, s1_read_d;
  logic          s1_err_q, s1_err_d;
  logic [1:0]    fifo_cnt_q, fifo_cnt_d;
  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic [DW:0]   fifo_mem_q [2];

  logic          accept;
  logic          addr_ok;
  logic          credit_ok;
  logic          ls_block;
  logic          fifo_nonempty;
  logic          push;
  logic          pop;
  logic [DW-1:0] s1_rdata;
  logic [DW:0]   s1_entry;
  logic [DW:0]   head_entry;

  // Zero-extend so DP == 2**AW still compares correctly.
  assign addr_ok   = ({{(32-AW){1'b0}}, icb_cmd_addr} < 32'(DP));
  assign credit_ok = (({1'b0, s1_vld_q} + fifo_cnt_q) < 2'd2);

  assign icb_cmd_ready = credit_ok & ~ls_block;
  assign accept        = icb_cmd_valid & icb_cmd_ready;

  assign ram_cs   = accept & addr_ok;
  assign ram_we   = ~icb_cmd_read;
  assign ram_wem  = icb_cmd_read ? '0 : icb_cmd_wmask;
  assign ram_addr = icb_cmd_addr;
  assign ram_din  = icb_cmd_wdata;
  assign ram_sd   = 1'b0;
  assign ram_ds   = 1'b0;

  assign s1_rdata   = (s1_read_q & ~s1_err_q) ? ram_dout : '0;
  assign s1_entry   = {s1_rdata, s1_err_q};
  assign head_entry = fifo_mem_q[rd_ptr_q];

  assign fifo_nonempty = (fifo_cnt_q != 2'd0);
  assign icb_rsp_valid = fifo_nonempty | s1_vld_q;
  assign icb_rsp_rdata = fifo_nonempty ? head_entry[DW:1] : s1_entry[DW:1];
  assign icb_rsp_err   = fifo_nonempty ? head_entry[0]    : s1_entry[0];

  // S1 bypasses the FIFO only when the FIFO is empty and the consumer takes it now.
  assign push = s1_vld_q & (fifo_nonempty | ~icb_rsp_ready);
  assign pop  = icb_rsp_valid & icb_rsp_ready & fifo_nonempty;

  always_comb begin
    s1_vld_d   = accept;
    s1_read_d  = s1_read_q;
    s1_err_d   = s1_err_q;
    fifo_cnt_d = fifo_cnt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (accept) begin
      s1_read_d = icb_cmd_read;
      s1_err_d  = ~addr_ok;
    end
    if (push) wr_ptr_d = ~wr_ptr_q;
    if (pop)  rd_ptr_d = ~rd_ptr_q;
    case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 2'd1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 2'd1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q   <= 1'b0;
      s1_read_q  <= 1'b0;
      s1_err_q   <= 1'b0;
      fifo_cnt_q <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
    end else begin
      s1_vld_q   <= s1_vld_d;
      s1_read_q  <= s1_read_d;
      s1_err_q   <= s1_err_d;
      fifo_cnt_q <= fifo_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= s1_entry;
  end

`ifdef E203_ITCM_CTRL_LS_EN
  localparam logic [7:0] IDLE_CYC = 8'(IDLE_LS_CYC);

  logic [7:0] idle_cnt_q, idle_cnt_d;
  logic       ram_ls_q, ram_ls_d;
  logic       rsp_pending;

  assign rsp_pending = s1_vld_q | fifo_nonempty;
  assign ls_block    = ram_ls_q;
  assign ram_ls      = ram_ls_q;

  // While asleep the counter sits saturated; a waking command resets both.
  always_comb begin
    idle_cnt_d = idle_cnt_q;
    ram_ls_d   = ram_ls_q;
    if (ram_ls_q) begin
      if (icb_cmd_valid) begin
        ram_ls_d   = 1'b0;
        idle_cnt_d = 8'd0;
      end
    end else if (ram_cs) begin
      idle_cnt_d = 8'd0;
    end else begin
      if (idle_cnt_q != IDLE_CYC) idle_cnt_d = idle_cnt_q + 8'd1;
      if ((idle_cnt_q == IDLE_CYC) && !rsp_pending) ram_ls_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt_q <= 8'd0;
      ram_ls_q   <= 1'b0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
      ram_ls_q   <= ram_ls_d;
    end
  end
`else
  assign ls_block = 1'b0;
  assign ram_ls   = 1'b0;
`endif

endmodule

// File: tb/tb_e203_itcm_sram_ctrl.sv
// Table-driven bench for e203_itcm_sram_ctrl (DP = 100) with a behavioural SRAM model,
// plus hand sequences for async reset and light-sleep wake (E203_ITCM_CTRL_LS_EN).
module tb_e203_itcm_sram_ctrl;

  localparam int DP = 100;
  localparam int AW = 13;
  localparam int DW = 64;
  localparam int MW = 8;

  localparam logic [63:0] D0 = 64'h1122334455667788;
  localparam logic [63:0] D1 = 64'hAABBCCDDEEFF0011;
  localparam logic [63:0] D1M = 64'h00000000EEFF0011;
  localparam logic [63:0] D2 = 64'h0123456789ABCDEF;
  localparam logic [63:0] D3 = 64'hDEADBEEFCAFEF00D;
  localparam logic [63:0] D4 = 64'h5A5A5A5AA5A5A5A5;
  localparam logic [63:0] D5 = 64'hFFFFFFFFFFFFFFFF;

  logic          clk;
  logic          rst_n;
  logic          icb_cmd_valid;
  logic          icb_cmd_ready;
  logic          icb_cmd_read;
  logic [AW-1:0] icb_cmd_addr;
  logic [DW-1:0] icb_cmd_wdata;
  logic [MW-1:0] icb_cmd_wmask;
  logic          icb_rsp_valid;
  logic          icb_rsp_ready;
  logic [DW-1:0] icb_rsp_rdata;
  logic          icb_rsp_err;
  logic          ram_cs;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [MW-1:0] ram_wem;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;
  logic          ram_sd;
  logic          ram_ds;
  logic          ram_ls;

  int errors = 0;
  int checks = 0;

  e203_itcm_sram_ctrl #(.DP(DP), .AW(AW), .DW(DW), .MW(MW), .IDLE_LS_CYC(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .icb_cmd_valid(icb_cmd_valid), .icb_cmd_ready(icb_cmd_ready),
    .icb_cmd_read(icb_cmd_read), .icb_cmd_addr(icb_cmd_addr),
    .icb_cmd_wdata(icb_cmd_wdata), .icb_cmd_wmask(icb_cmd_wmask),
    .icb_rsp_valid(icb_rsp_valid), .icb_rsp_ready(icb_rsp_ready),
    .icb_rsp_rdata(icb_rsp_rdata), .icb_rsp_err(icb_rsp_err),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wem(ram_wem),
    .ram_din(ram_din), .ram_dout(ram_dout),
    .ram_sd(ram_sd), .ram_ds(ram_ds), .ram_ls(ram_ls)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAM: byte-masked write, registered read.
  logic [63:0] mem [0:127];
  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 64'd0;
    ram_dout = 64'd0;
  end
  always @(posedge clk) begin : ram_model
    logic [63:0] tmp;
    if (ram_cs) begin
      if (ram_we) begin
        tmp = mem[ram_addr[6:0]];
        for (int b = 0; b < 8; b++) if (ram_wem[b]) tmp[b*8 +: 8] = ram_din[b*8 +: 8];
        mem[ram_addr[6:0]] <= tmp;
      end else begin
        ram_dout <= mem[ram_addr[6:0]];
      end
    end
  end

  typedef struct packed {
    logic        vld;
    logic        rd;
    logic [12:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    logic        rr;
    logic        e_rdy;
    logic        e_cs;
    logic        e_we;
    logic [7:0]  e_wem;
    logic        e_rv;
    logic [63:0] e_rdata;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic vld, input logic rd, input int addr,
                              input logic [63:0] wdata, input logic [7:0] wmask, input logic rr,
                              input logic e_rdy, input logic e_cs, input logic e_we,
                              input logic [7:0] e_wem, input logic e_rv,
                              input logic [63:0] e_rdata, input logic e_err);
    vec_t v;
    v.vld = vld; v.rd = rd; v.addr = 13'(addr); v.wdata = wdata; v.wmask = wmask; v.rr = rr;
    v.e_rdy = e_rdy; v.e_cs = e_cs; v.e_we = e_we; v.e_wem = e_wem;
    v.e_rv = e_rv; v.e_rdata = e_rdata; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic drive(input logic vld, input logic rd, input int addr,
                       input logic [63:0] wdata, input logic [7:0] wmask, input logic rr);
    icb_cmd_valid = vld;
    icb_cmd_read  = rd;
    icb_cmd_addr  = 13'(addr);
    icb_cmd_wdata = wdata;
    icb_cmd_wmask = wmask;
    icb_rsp_ready = rr;
  endtask

  task automatic idle(input logic rr);
    drive(1'b0, 1'b1, 0, 64'd0, 8'h00, rr);
  endtask

  initial begin
    int waited;
    // vld rd addr wdata wmask rr | rdy cs we wem rv rdata err
    vecs.push_back(mk(0,1,  0,64'd0,8'h00,1, 1,0,0,8'h00, 0,64'd0,0));
    vecs.push_back(mk(1,0,  5,D0   ,8'hFF,1, 1,1,1,8'hFF, 0,64'd0,0));
    vecs.push_back(mk(1,0,  6,D1   ,8'h0F,1, 1,1,1,8'h0F, 1,64'd0,0));
    vecs.push_back(mk(1,0,  7,D2   ,8'hFF,1, 1,1,1,8'hFF, 1,64'd0,0));
    vecs.push_back(mk(1,0,  8,D3   ,8'h00,1, 1,1,1,8'h00, 1,64'd0,0));
    vecs.push_back(mk(1,1,  5,64'd0,8'hFF,1, 1,1,0,8'h00, 1,64'd0,0));
    vecs.push_back(mk(1,1,  6,64'd0,8'hFF,1, 1,1,0,8'h00, 1,D0   ,0));
    vecs.push_back(mk(1,1,  7,64'd0,8'hFF,1, 1,1,0,8'h00, 1,D1M  ,0));
    vecs.push_back(mk(1,1,  8,64'd0,8'hFF,1, 1,1,0,8'h00, 1,D2   ,0));
    vecs.push_back(mk(0,1,  0,64'd0,8'h00,1, 1,0,0,8'h00, 1,64'd0,0));
    vecs.push_back(mk(1,0, 99,D4   ,8'hFF,1, 1,1,1,8'hFF, 0,64'd0,0));
    vecs.push_back(mk(1,1,100,64'd0,8'hFF,1, 1,0,0,8'h00, 1,64'd0,0));
    vecs.push_back(mk(1,1, 99,64'd0,8'hFF,1, 1,1,0,8'h00, 1,64'd0,1));
    vecs.push_back(mk(0,1,  0,64'd0,8'h00,1, 1,0,0,8'h00, 1,D4   ,0));
    vecs.push_back(mk(1,0,200,D5   ,8'hFF,1, 1,0,1,8'hFF, 0,64'd0,0));
    vecs.push_back(mk(0,1,  0,64'd0,8'h00,1, 1,0,0,8'h00, 1,64'd0,1));
    vecs.push_back(mk(0,1,  0,64'd0,8'h00,1, 1,0,0,8'h00, 0,64'd0,0));
    // Back-pressure: two responses fill S1+FIFO, third command stalls until credit returns.
    vecs.push_back(mk(1,1,  5,64'd0,8'h00,0, 1,1,0,8'h00, 0,64'd0,0));
    vecs.push_back(mk(1,1,  7,64'd0,8'h00,0, 1,1,0,8'h00, 1,D0   ,0));
    vecs.push_back(mk(1,1,  6,64'd0,8'h00,0, 0,0,0,8'h00, 1,D0   ,0));
    vecs.push_back(mk(1,1,  6,64'd0,8'h00,1, 0,0,0,8'h00, 1,D0   ,0));
    vecs.push_back(mk(1,1,  6,64'd0,8'h00,1, 1,1,0,8'h00, 1,D2   ,0));
    vecs.push_back(mk(0,1,  0,64'd0,8'h00,1, 1,0,0,8'h00, 1,D1M  ,0));
    vecs.push_back(mk(0,1,  0,64'd0,8'h00,1, 1,0,0,8'h00, 0,64'd0,0));

    rst_n = 1'b0;
    idle(1'b1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].vld, vecs[i].rd, int'(vecs[i].addr), vecs[i].wdata, vecs[i].wmask, vecs[i].rr);
      #1;
      chk($sformatf("v%0d_cmd", i),
          96'({icb_cmd_ready, ram_cs, ram_we, ram_wem, icb_rsp_valid, ram_sd, ram_ds}),
          96'({vecs[i].e_rdy, vecs[i].e_cs, vecs[i].e_we, vecs[i].e_wem, vecs[i].e_rv, 2'b00}));
      if (vecs[i].e_rv)
        chk($sformatf("v%0d_rsp", i), 96'({icb_rsp_rdata, icb_rsp_err}),
            96'({vecs[i].e_rdata, vecs[i].e_err}));
    end

    // Async reset with two responses pending.
    @(negedge clk); drive(1'b1, 1'b1, 5, 64'd0, 8'h00, 1'b0);
    @(negedge clk); drive(1'b1, 1'b1, 7, 64'd0, 8'h00, 1'b0);
    @(negedge clk); idle(1'b0);
    #1;
    chk("rst_pre_pending", 96'({icb_rsp_valid, icb_cmd_ready}), 96'({1'b1, 1'b0}));
    rst_n = 1'b0;
    #1;
    chk("rst_async_drop", 96'({icb_rsp_valid, icb_cmd_ready}), 96'({1'b0, 1'b1}));
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 1'b1, 7, 64'd0, 8'h00, 1'b1);
    #1;
    chk("rst_release", 96'({icb_rsp_valid, icb_cmd_ready, ram_cs}), 96'({1'b0, 1'b1, 1'b1}));
    @(negedge clk); idle(1'b1);
    #1;
    chk("rst_first_rsp", 96'({icb_rsp_valid, icb_rsp_rdata, icb_rsp_err}), 96'({1'b1, D2, 1'b0}));

`ifdef E203_ITCM_CTRL_LS_EN
    waited = 0;
    while (ram_ls !== 1'b1 && waited < 40) begin
      @(negedge clk); #1;
      waited++;
    end
    checks++;
    if (ram_ls !== 1'b1) begin
      errors++;
      $display("FAIL ls_entry: ram_ls=%b after %0d idle cycles, required 1", ram_ls, waited);
    end else begin
      $display("ok   ls_entry after %0d cycles", waited);
    end
    chk("ls_idle_window", 96'(waited >= 16 && waited <= 19), 96'(1));
    @(negedge clk); drive(1'b1, 1'b1, 5, 64'd0, 8'h00, 1'b1);
    #1;
    chk("ls_asleep", 96'({ram_ls, icb_cmd_ready, ram_cs}), 96'({1'b1, 1'b0, 1'b0}));
    @(negedge clk); #1;
    chk("ls_wake", 96'({ram_ls, icb_cmd_ready, ram_cs}), 96'({1'b0, 1'b1, 1'b1}));
    @(negedge clk); idle(1'b1);
    #1;
    chk("ls_read_rsp", 96'({icb_rsp_valid, icb_rsp_rdata, icb_rsp_err}), 96'({1'b1, D0, 1'b0}));
`else
    waited = 0;
    repeat (20) begin
      @(negedge clk);
      waited++;
    end
    #1;
    chk("ls_tied_low", 96'({ram_ls, icb_cmd_ready}), 96'({1'b0, 1'b1}));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
